inst_buffer: RTL and testbench

Instruction buffer between predecode and decode. Accepts up to `BLOCK_INST_SIZE` predecoded instructions per cycle from the predecode stage on the `PreDecodeIBufferIO` instbuffer side. Delivers up to `FETCH_WIDTH` instructions per cycle in program order to the decode stage as the `fetchBundle` producer of `IfuBackendIO`. Decouples fetch-block granularity from decode width and absorbs backend stalls.

---
 rtl/inst_buffer.sv | 148 ++++++++++++++
 tb/tb_inst_buffer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
//------------------------------------------------------------------------------
// Module     : inst_buffer
// Description: Circular instruction buffer between predecode and decode.
//              Takes up to BLOCK_INST_SIZE instructions per cycle and hands
//              up to FETCH_WIDTH per cycle to decode, in program order.
//              Optional macro IBUF_PERF_EN adds saturating perf counters.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_buffer #(
  parameter int DEPTH            = 16,
  parameter int BLOCK_INST_SIZE  = 8,
  parameter int FETCH_WIDTH      = 4,
  parameter int FSQ_WIDTH        = 6,
  parameter int PREDICTION_WIDTH = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [BLOCK_INST_SIZE-1:0]                    in_en,
  input  logic [$clog2(BLOCK_INST_SIZE):0]              in_num,
  input  logic [BLOCK_INST_SIZE-1:0][31:0]              in_inst,
  input  logic                                          in_iam,
  input  logic [FSQ_WIDTH-1:0]                          in_fsqIdx,
  input  logic [PREDICTION_WIDTH:0]                     in_shiftIdx,
  output logic                                          full,
  output logic [FETCH_WIDTH-1:0]                        out_en,
  output logic [FETCH_WIDTH-1:0][31:0]                  out_inst,
  output logic [FETCH_WIDTH-1:0]                        out_iam,
  output logic [FETCH_WIDTH-1:0][FSQ_WIDTH-1:0]         out_fsqIdx,
  output logic [FETCH_WIDTH-1:0][PREDICTION_WIDTH:0]    out_offset,
  input  logic                                          stall,
  input  logic                                          flush
`ifdef IBUF_PERF_EN
  ,
  output logic [31:0]                                   perf_full_cycles,
  output logic [31:0]                                   perf_deq_insts
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int OW = PREDICTION_WIDTH + 1;

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] BLOCK_P = PW'(BLOCK_INST_SIZE);
  localparam logic [PW-1:0] FETCH_P = PW'(FETCH_WIDTH);

  logic [31:0]          mem_inst   [DEPTH];
  logic                 mem_iam    [DEPTH];
  logic [FSQ_WIDTH-1:0] mem_fsq    [DEPTH];
  logic [OW-1:0]        mem_off    [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] count;
  logic [PW-1:0] count_next;
  logic [PW-1:0] enq_num;
  logic [PW-1:0] deq_num;
  logic [PW-1:0] free_next;
  logic          enq;
  logic          deq;
  logic          full_next;

  logic [IW-1:0] wr_idx [BLOCK_INST_SIZE];
  logic [OW-1:0] wr_off [BLOCK_INST_SIZE];
  logic          wr_iam [BLOCK_INST_SIZE];
  logic [IW-1:0] rd_idx [FETCH_WIDTH];

  assign count = tail - head;
  assign enq   = (|in_en) && !full && !flush;
  assign deq   = !stall && !flush;

  always_comb begin
    enq_num = '0;
    deq_num = '0;
    if (enq) begin
      enq_num = PW'(in_num);
    end
    if (deq) begin
      deq_num = (count > FETCH_P) ? FETCH_P : count;
    end
  end

  assign count_next = count + enq_num - deq_num;
  assign free_next  = DEPTH_P - count_next;
  // Only a whole-block gap counts as room, so no partial enqueue can happen.
  assign full_next  = free_next < BLOCK_P;

  for (genvar i = 0; i < BLOCK_INST_SIZE; i++) begin : g_wr_lane
    assign wr_idx[i] = tail[IW-1:0] + IW'(i);
    assign wr_off[i] = in_shiftIdx + OW'(i);
    assign wr_iam[i] = in_iam & (i == 0);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
      if (enq && in_en[i]) begin
        mem_inst[wr_idx[i]] <= in_inst[i];
        mem_iam[wr_idx[i]]  <= wr_iam[i];
        mem_fsq[wr_idx[i]]  <= in_fsqIdx;
        mem_off[wr_idx[i]]  <= wr_off[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head <= '0;
      tail <= '0;
      full <= 1'b0;
    end else begin
      head <= head + deq_num;
      tail <= tail + enq_num;
      full <= full_next;
    end
  end

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_rd_lane
    assign rd_idx[i]     = head[IW-1:0] + IW'(i);
    assign out_en[i]     = PW'(i) < count;
    assign out_inst[i]   = mem_inst[rd_idx[i]];
    assign out_iam[i]    = mem_iam[rd_idx[i]];
    assign out_fsqIdx[i] = mem_fsq[rd_idx[i]];
    assign out_offset[i] = mem_off[rd_idx[i]];
  end

`ifdef IBUF_PERF_EN
  logic [32:0] full_sum;
  logic [32:0] deq_sum;

  assign full_sum = {1'b0, perf_full_cycles} + 33'(full);
  assign deq_sum  = {1'b0, perf_deq_insts} + 33'(deq_num);

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_full_cycles <= '0;
      perf_deq_insts   <= '0;
    end else begin
      perf_full_cycles <= full_sum[32] ? '1 : full_sum[31:0];
      perf_deq_insts   <= deq_sum[32]  ? '1 : deq_sum[31:0];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_buffer.sv
//------------------------------------------------------------------------------
// Module     : tb_inst_buffer
// Description: Directed scoreboard bench for inst_buffer (IBUF_PERF_EN aware).
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_inst_buffer;

  typedef struct packed {
    logic [31:0] inst;
    logic        iam;
    logic [5:0]  fsq;
    logic [4:0]  off;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       in_en;
  logic [3:0]       in_num;
  logic [7:0][31:0] in_inst;
  logic             in_iam;
  logic [5:0]       in_fsqIdx;
  logic [4:0]       in_shiftIdx;
  logic             full;
  logic [3:0]       out_en;
  logic [3:0][31:0] out_inst;
  logic [3:0]       out_iam;
  logic [3:0][5:0]  out_fsqIdx;
  logic [3:0][4:0]  out_offset;
  logic             stall;
  logic             flush;
`ifdef IBUF_PERF_EN
  logic [31:0]      perf_full_cycles;
  logic [31:0]      perf_deq_insts;
`endif

  int     tests = 0;
  int     fails = 0;
  entry_t exp_q[$];
  entry_t mon_e;

  always #5 clk = ~clk;

  inst_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .in_en      (in_en),
    .in_num     (in_num),
    .in_inst    (in_inst),
    .in_iam     (in_iam),
    .in_fsqIdx  (in_fsqIdx),
    .in_shiftIdx(in_shiftIdx),
    .full       (full),
    .out_en     (out_en),
    .out_inst   (out_inst),
    .out_iam    (out_iam),
    .out_fsqIdx (out_fsqIdx),
    .out_offset (out_offset),
    .stall      (stall),
    .flush      (flush)
`ifdef IBUF_PERF_EN
    ,
    .perf_full_cycles(perf_full_cycles),
    .perf_deq_insts  (perf_deq_insts)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_en  = '0;
    in_num = '0;
  endtask

  // Presents an n-lane block; lane i carries base + i*0x80.
  task automatic drive_blk(input int n, input logic [31:0] base, input logic [5:0] fsq,
                           input logic [4:0] sh, input logic iam, input bit push);
    entry_t e;
    in_en   = '0;
    in_inst = '0;
    for (int i = 0; i < n; i++) begin
      in_en[i]   = 1'b1;
      in_inst[i] = base + 32'(i) * 32'h80;
      if (push) begin
        e.inst = in_inst[i];
        e.iam  = (i == 0) ? iam : 1'b0;
        e.fsq  = fsq;
        e.off  = sh + 5'(i);
        exp_q.push_back(e);
      end
    end
    in_num      = 4'(n);
    in_iam      = iam;
    in_fsqIdx   = fsq;
    in_shiftIdx = sh;
  endtask

  // Every lane consumed by decode must match the next expected instruction.
  always @(negedge clk) begin
    if (rst && !stall && !flush) begin
      for (int i = 0; i < 4; i++) begin
        if (out_en[i]) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected lane %0d: got inst %h, required no output", i, out_inst[i]);
          end else begin
            mon_e = exp_q.pop_front();
            if ({out_inst[i], out_iam[i], out_fsqIdx[i], out_offset[i]} !== mon_e) begin
              fails++;
              $display("FAIL sb_lane%0d: got inst %h iam %b fsq %0d off %0d, required inst %h iam %b fsq %0d off %0d",
                       i, out_inst[i], out_iam[i], out_fsqIdx[i], out_offset[i],
                       mon_e.inst, mon_e.iam, mon_e.fsq, mon_e.off);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    in_iam = 1'b0; in_fsqIdx = '0; in_shiftIdx = '0; in_inst = '0;
    idle();
    step();
    step();
    chk("rst_out_en", 32'(out_en), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    rst = 1'b1;

    // Single block drained at full decode rate
    drive_blk(8, 32'h13, 6'd3, 5'd2, 1'b1, 1'b1);
    step();
    idle();
    chk("blk_out_en0", 32'(out_en), 32'hF);
    for (int k = 0; k < 4; k++) chk("blk_offset0", 32'(out_offset[k]), 32'(2 + k));
    chk("blk_full", 32'(full), 32'h0);
    step();
    chk("blk_out_en1", 32'(out_en), 32'hF);
    chk("blk_offset1", 32'(out_offset[3]), 32'd9);
    step();
    chk("blk_empty", 32'(out_en), 32'h0);

    // Backpressure until full, third block ignored
    stall = 1'b1;
    drive_blk(8, 32'h1000, 6'd1, 5'd0, 1'b0, 1'b1);
    step();
    drive_blk(8, 32'h2000, 6'd2, 5'd8, 1'b0, 1'b1);
    step();
    chk("full_rise", 32'(full), 32'h1);
    drive_blk(8, 32'h3000, 6'd9, 5'd0, 1'b1, 1'b0);
    step();
    idle();
    chk("full_hold", 32'(full), 32'h1);
    stall = 1'b0;
    step();
    chk("full_cnt12", 32'(full), 32'h1);
    step();
    chk("full_fall", 32'(full), 32'h0);
    step();
    step();
    chk("full_drained", 32'(out_en), 32'h0);

    // Pointer wrap: bring head/tail to slot 14 then split A..E across the end
    drive_blk(6, 32'h500, 6'd4, 5'd0, 1'b0, 1'b1);
    step();
    idle();
    step();
    step();
    chk("wrap_pre_empty", 32'(out_en), 32'h0);
    drive_blk(5, 32'hA000, 6'd7, 5'd1, 1'b0, 1'b1);
    step();
    idle();
    chk("wrap_en0", 32'(out_en), 32'hF);
    chk("wrap_inst_a", out_inst[0], 32'hA000);
    chk("wrap_inst_d", out_inst[3], 32'hA180);
    step();
    chk("wrap_en1", 32'(out_en), 32'h1);
    chk("wrap_inst_e", out_inst[0], 32'hA200);
    step();
    chk("wrap_empty", 32'(out_en), 32'h0);

    // Enqueue 3 and dequeue 4 together from count 6
    stall = 1'b1;
    drive_blk(6, 32'h6000, 6'd5, 5'd0, 1'b0, 1'b1);
    step();
    stall = 1'b0;
    drive_blk(3, 32'h7000, 6'd6, 5'd0, 1'b0, 1'b1);
    step();
    idle();
    chk("simul_en", 32'(out_en), 32'hF);
    chk("simul_head", out_inst[0], 32'h6200);
    step();
    chk("simul_en_last", 32'(out_en), 32'h1);
    chk("simul_last", out_inst[0], 32'h7100);
    step();
    chk("simul_empty", 32'(out_en), 32'h0);

    // Flush drops a same-cycle enqueue while not full
    stall = 1'b1;
    drive_blk(2, 32'h4000, 6'd1, 5'd0, 1'b0, 1'b1);
    step();
    flush = 1'b1;
    drive_blk(4, 32'h4800, 6'd1, 5'd0, 1'b0, 1'b0);
    exp_q.delete();
    step();
    flush = 1'b0;
    idle();
    chk("flush_small_en", 32'(out_en), 32'h0);

    // Flush at count 10 alongside an 8-lane block
    drive_blk(8, 32'h8000, 6'd2, 5'd0, 1'b0, 1'b1);
    step();
    drive_blk(2, 32'h9000, 6'd2, 5'd8, 1'b0, 1'b1);
    step();
    flush = 1'b1;
    drive_blk(8, 32'hB000, 6'd3, 5'd0, 1'b1, 1'b0);
    exp_q.delete();
    step();
    flush = 1'b0;
    idle();
    chk("flush_en", 32'(out_en), 32'h0);
    chk("flush_full", 32'(full), 32'h0);
    stall = 1'b0;
    drive_blk(3, 32'hC000, 6'd5, 5'd7, 1'b1, 1'b1);
    step();
    idle();
    chk("post_flush_en", 32'(out_en), 32'h7);
    chk("post_flush_inst", out_inst[0], 32'hC000);
    chk("post_flush_fsq", 32'(out_fsqIdx[0]), 32'd5);
    chk("post_flush_iam", 32'(out_iam), 32'h1);
    chk("post_flush_off", 32'(out_offset[2]), 32'd9);
    step();
    chk("post_flush_empty", 32'(out_en), 32'h0);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

`ifdef IBUF_PERF_EN
    rst = 1'b0;
    step();
    rst = 1'b1;
    exp_q.delete();
    chk("perf_rst_full", perf_full_cycles, 32'd0);
    chk("perf_rst_deq", perf_deq_insts, 32'd0);
    stall = 1'b1;
    drive_blk(8, 32'hD000, 6'd1, 5'd0, 1'b0, 1'b1);
    step();
    drive_blk(8, 32'hE000, 6'd1, 5'd8, 1'b0, 1'b1);
    step();
    idle();
    step();
    stall = 1'b0;
    step();
    step();
    step();
    stall = 1'b1;
    chk("perf_full_cycles", perf_full_cycles, 32'd3);
    chk("perf_deq_insts", perf_deq_insts, 32'd12);
    rst = 1'b0;
    step();
    rst = 1'b1;
    exp_q.delete();
    chk("perf_rst2_full", perf_full_cycles, 32'd0);
    chk("perf_rst2_deq", perf_deq_insts, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
